ex_muldiv_unit: RTL

Parametrised multi-cycle RV32M/RV64M execution unit sitting beside the single-cycle ALU in the EX stage.
- Accepts one already-forwarded operand pair plus funct3 and destination tag.
- Computes MUL/MULH/MULHSU/MULHU through a configurable-latency multiplier and DIV/DIVU/REM/REMU through an iterative radix-2 divider.
- Returns a tagged result; drives `busy` so the hazard unit stalls IF/ID/EX while an op is in flight.

---
 rtl/ex_pkg.sv | 27 ++
 rtl/ex_muldiv_unit_if.sv | 27 ++
 rtl/div_iter.sv | 62 ++++++
 rtl/ex_muldiv_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
package ex_pkg;

    // RV32M/RV64M funct3 encodings.
    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StMul  = 3'd1,
        StDiv  = 3'd2,
        StFix  = 3'd3,
        StDone = 3'd4
    } muldiv_state_e;

    // funct3 bit separating the divide ops from the multiply ops.
    localparam int unsigned FUNCT3_DIV_BIT = 2;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, funct3, op_a, op_b, in_tag, flush,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  in_valid, funct3, op_a, op_b, in_tag, flush,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider core on unsigned magnitudes; one quotient bit per cycle.
module div_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            last_o,
    output logic            done_o
);
    // One extra bit so the counter can sit at XLEN without wrapping.
    localparam int unsigned CntW = $clog2(XLEN) + 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [XLEN:0]   shifted, diff;

    // Shift in the next dividend bit and keep the difference when it does not borrow.
    always_comb begin
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (start_i) begin
            cnt_d = '0;
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
        end else if (cnt_q < CntW'(XLEN)) begin
            rem_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Iteration state; the counter idles at XLEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CntW'(XLEN);
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign last_o      = (cnt_q == CntW'(XLEN - 1));
    assign done_o      = (cnt_q == CntW'(XLEN));

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M/RV64M unit: pipelined multiplier plus iterative divider.
module ex_muldiv_unit
    import ex_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned TAG_W      = 5
) (
    input logic               clk,
    input logic               rst_n,
    ex_muldiv_unit_if.slave   bus
);
    localparam int unsigned MulCntW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e            state_q, state_d;
    logic [MulCntW-1:0]       mul_cnt_q, mul_cnt_d;
    logic [MUL_STAGES-1:0][XLEN-1:0] mul_pipe_q;
    logic [XLEN-1:0]          out_result_q, spec_res_q, res_sel;
    logic [TAG_W-1:0]         out_tag_q, tag_q;
    logic                     is_rem_q, neg_quo_q, neg_rem_q, special_q;
    logic                     load_res;

    muldiv_op_e               op_in;
    logic                     accept, is_div_in, sgn_in, a_neg, b_neg, by_zero, special_in;
    logic [XLEN-1:0]          mag_a, mag_b, spec_res, mul_res, quo, rem, fix_res;
    logic [2*XLEN-1:0]        a_wide, b_wide, prod;
    logic                     div_start, div_last, div_done;

    assign accept = bus.in_valid && bus.in_ready && !bus.flush;

    // Operand decode, multiplier front end and divide special-case detection.
    always_comb begin
        op_in      = muldiv_op_e'(bus.funct3);
        is_div_in  = bus.funct3[FUNCT3_DIV_BIT];
        a_wide     = {{XLEN{(op_in != OpMulhu) & bus.op_a[XLEN-1]}}, bus.op_a};
        b_wide     = {{XLEN{(op_in == OpMul || op_in == OpMulh) & bus.op_b[XLEN-1]}}, bus.op_b};
        prod       = a_wide * b_wide;
        mul_res    = (op_in == OpMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        sgn_in     = ~bus.funct3[0];
        a_neg      = sgn_in & bus.op_a[XLEN-1];
        b_neg      = sgn_in & bus.op_b[XLEN-1];
        mag_a      = a_neg ? -bus.op_a : bus.op_a;
        mag_b      = b_neg ? -bus.op_b : bus.op_b;
        by_zero    = (bus.op_b == '0);
        special_in = by_zero || (sgn_in && bus.op_a == MinInt && bus.op_b == '1);
        // Overflow quotient is MIN_INT, which is op_a itself.
        if (bus.funct3[1]) spec_res = by_zero ? bus.op_a : '0;
        else               spec_res = by_zero ? '1 : bus.op_a;
    end

    assign div_start = accept && is_div_in && !special_in;

    div_iter #(
        .XLEN (XLEN)
    ) u_div_iter (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (div_start),
        .dividend_i  (mag_a),
        .divisor_i   (mag_b),
        .quotient_o  (quo),
        .remainder_o (rem),
        .last_o      (div_last),
        .done_o      (div_done)
    );

    // Sign correction; special cases also pass through FIX so every divide registers alike.
    always_comb begin
        if (special_q)     fix_res = spec_res_q;
        else if (is_rem_q) fix_res = neg_rem_q ? -rem : rem;
        else               fix_res = neg_quo_q ? -quo : quo;
        res_sel = (state_q == StMul) ? mul_pipe_q[MUL_STAGES-1] : fix_res;
    end

    // Next-state logic; flush overrides everything and suppresses the result write.
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        load_res  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mul_cnt_d = '0;
                    if (!is_div_in)     state_d = StMul;
                    else if (special_in) state_d = StFix;
                    else                 state_d = StDiv;
                end
            end
            StMul: begin
                if (mul_cnt_q == MulCntW'(MUL_STAGES - 1)) begin
                    state_d  = StDone;
                    load_res = 1'b1;
                end else begin
                    mul_cnt_d = mul_cnt_q + MulCntW'(1);
                end
            end
            StDiv:  if (div_last) state_d = StFix;
            StFix: begin
                if (special_q || div_done) begin
                    state_d  = StDone;
                    load_res = 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (bus.flush) begin
            state_d  = StIdle;
            load_res = 1'b0;
        end
    end

    // Control state, op attributes latched at accept, and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mul_cnt_q    <= '0;
            tag_q        <= '0;
            is_rem_q     <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            special_q    <= 1'b0;
            spec_res_q   <= '0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            if (accept) begin
                tag_q      <= bus.in_tag;
                is_rem_q   <= bus.funct3[1];
                neg_quo_q  <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                special_q  <= special_in;
                spec_res_q <= spec_res;
            end
            if (load_res) begin
                out_result_q <= res_sel;
                out_tag_q    <= tag_q;
            end
        end
    end

    // Free-running multiplier chain; slot k holds the product accepted k edges earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_pipe_q <= '0;
        end else begin
            mul_pipe_q[0] <= mul_res;
            for (int i = 1; i < int'(MUL_STAGES); i++) begin
                mul_pipe_q[i] <= mul_pipe_q[i-1];
            end
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle) && (state_q != StDone);
    assign bus.out_valid  = (state_q == StDone);
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;

endmodule
